// File: rtl/taylor_series_control.sv
// Taylor-series sequencer for the exponential unit.
// Steps one shared multiplier and an accumulating adder through NUM_TERMS
// terms (power multiply, coefficient multiply, accumulate). It also provides
// a start/ack result handshake, an abort input and a coefficient ROM index.
// Outputs are a Moore decode of the state. They are registered from the
// next state, so they change on the same edge as the state itself.
module taylor_series_control #(
  parameter int NUM_TERMS = 4,
  parameter int TERM_W    = 3,
  parameter int MUL_LAT   = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ack,
  output logic              ready,
  output logic              busy,
  output logic              output_ready,
  output logic              acc_clr,
  output logic              mul_ss,
  output logic              mul_ss_en,
  output logic              add_ss_en,
  output logic [TERM_W-1:0] term_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_POW    = 3'd2;
  localparam logic [2:0] S_WAIT_P = 3'd3;
  localparam logic [2:0] S_COEF   = 3'd4;
  localparam logic [2:0] S_WAIT_C = 3'd5;
  localparam logic [2:0] S_ADD    = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  // The wait counter is loaded with MUL_LAT-1. It runs down to zero, which
  // gives exactly MUL_LAT idle cycles.
  localparam logic [3:0]        WAIT_INIT = (MUL_LAT > 0) ? 4'(MUL_LAT - 1) : 4'd0;
  localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(NUM_TERMS - 1);

  // Output vector order: {ready, busy, output_ready, acc_clr, mul_ss, mul_ss_en, add_ss_en}
  localparam logic [6:0] OUT_RESET = 7'b1000000;

  logic [2:0]        state_q, state_d;
  logic [TERM_W-1:0] term_q, term_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [6:0]        out_q;

  // Moore output decode for a given state.
  function automatic logic [6:0] decode_outputs(input logic [2:0] st);
    logic [6:0] o;
    case (st)
      S_IDLE:   o = 7'b1000000;
      S_LOAD:   o = 7'b0101000;
      S_POW:    o = 7'b0100110;
      S_WAIT_P: o = 7'b0100000;
      S_COEF:   o = 7'b0100010;
      S_WAIT_C: o = 7'b0100000;
      S_ADD:    o = 7'b0100001;
      S_DONE:   o = 7'b0010000;
      default:  o = 7'b1000000;
    endcase
    return o;
  endfunction

  // Next-state, term index and wait counter logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    wcnt_d  = wcnt_q;
    if (abort) begin
      // In IDLE this also blocks a simultaneous start.
      state_d = S_IDLE;
      term_d  = '0;
      wcnt_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            term_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: state_d = S_POW;
        S_POW: begin
          if (MUL_LAT > 0) begin
            state_d = S_WAIT_P;
            wcnt_d  = WAIT_INIT;
          end else begin
            state_d = S_COEF;
          end
        end
        S_WAIT_P: begin
          if (wcnt_q == 4'd0) begin
            state_d = S_COEF;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
        S_COEF: begin
          if (MUL_LAT > 0) begin
            state_d = S_WAIT_C;
            wcnt_d  = WAIT_INIT;
          end else begin
            state_d = S_ADD;
          end
        end
        S_WAIT_C: begin
          if (wcnt_q == 4'd0) begin
            state_d = S_ADD;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
        S_ADD: begin
          // The index advances only here, so it stops at the last term.
          if (term_q == LAST_TERM) begin
            state_d = S_DONE;
          end else begin
            term_d  = term_q + {{(TERM_W-1){1'b0}}, 1'b1};
            state_d = S_POW;
          end
        end
        S_DONE: begin
          if (out_ack) begin
            state_d = S_IDLE;
            term_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          term_d  = '0;
          wcnt_d  = 4'd0;
        end
      endcase
    end
  end

  // State registers, plus outputs registered from the decode of the next state.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      term_q  <= '0;
      wcnt_q  <= 4'd0;
      out_q   <= OUT_RESET;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      wcnt_q  <= wcnt_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  assign ready        = out_q[6];
  assign busy         = out_q[5];
  assign output_ready = out_q[4];
  assign acc_clr      = out_q[3];
  assign mul_ss       = out_q[2];
  assign mul_ss_en    = out_q[1];
  assign add_ss_en    = out_q[0];
  assign term_idx     = term_q;

endmodule
